ecc_scrub_controller: RTL and testbench

Sits in front of `ecc_hamming_faulty_memory` (the Hamming(12,8) SEC memory) and owns its address, write-data and write-enable inputs. It muxes host accesses with a background scrubber. The scrubber periodically walks every address, reads the corrected word, and writes it back when the memory flags a corrected single-bit error. Without this, a latent single-bit upset can accumulate into an uncorrectable double error.

---
 rtl/ecc_scrub_controller.sv | 169 ++++++++++++++++
 tb/tb_ecc_scrub_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_controller.sv
// ecc_scrub_controller
//
// Front end for the Hamming(12,8) SEC memory. It owns the memory address,
// write-data and write-enable lines and shares them between host accesses
// and a background scrubber. The scrubber walks addresses 0..DEPTH-1. Between
// reads it waits SCRUB_INTERVAL idle cycles. When the memory reports a
// corrected single-bit error, the scrubber writes the corrected word back,
// so that a latent upset cannot grow into an uncorrectable double error.
//
// Host handshake: host_req is the request and host_gnt is the same-cycle
// accept. A transfer happens in every cycle where host_req && host_gnt. The
// host holds host_req and its address/data stable until it sees host_gnt.
// host_ack pulses exactly one cycle after each grant. For a read, host_rdata
// is valid while host_ack is high.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   scrub_en            enable for the background scrubber
//   host_req/host_we    host request / 1 = write
//   host_addr/wdata     host address / write data
//   host_gnt            combinational accept (low only during write-back)
//   host_ack/rdata      registered acknowledge / read data
//   mem_addr/wdata/wr_en  drive the memory input_addr/input_data/wr_en
//   mem_rdata           memory output_data (combinational read of mem_addr)
//   mem_corrected       memory single_bit_error_corrected (combinational)
//   scrub_busy          registered; high during RD and WB cycles
//   pass_done           one-cycle pulse after the last address of a pass
//   corr_count          saturating count of write-backs
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 RD, 3 WB)
module ecc_scrub_controller #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_corrected,
  output logic              scrub_busy,
  output logic              pass_done,
  output logic [7:0]        corr_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RD   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [ADDR_W-1:0]   scrub_ptr, ptr_nx;
  logic [DATA_W-1:0]   scrub_data, data_nx;
  logic                ptr_adv;
  logic                count_inc;

  assign dbg_state = state;

  // Host wins everywhere except WB, so a write-back is never torn.
  assign host_gnt = host_req && (state != S_WB);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    data_nx   = scrub_data;
    ptr_adv   = 1'b0;
    count_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (scrub_en) begin
          state_nx = S_WAIT;
          cnt_nx   = CNT_RELOAD;
        end
      end
      S_WAIT: begin
        if (!scrub_en) begin
          state_nx = S_IDLE;
        end else if (!host_gnt) begin
          // The interval only counts cycles the memory was actually idle.
          if (cnt == '0) state_nx = S_RD;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
      end
      S_RD: begin
        // A granted host access steals the port. The read is retried next
        // cycle with the pointer unchanged.
        if (!host_gnt) begin
          data_nx = mem_rdata;
          if (mem_corrected) begin
            state_nx = S_WB;
          end else begin
            ptr_adv  = 1'b1;
            cnt_nx   = CNT_RELOAD;
            state_nx = scrub_en ? S_WAIT : S_IDLE;
          end
        end
      end
      S_WB: begin
        count_inc = 1'b1;
        ptr_adv   = 1'b1;
        cnt_nx    = CNT_RELOAD;
        state_nx  = scrub_en ? S_WAIT : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    ptr_nx = scrub_ptr;
    if (ptr_adv) ptr_nx = (scrub_ptr == LAST_PTR) ? '0 : scrub_ptr + ADDR_W'(1);
  end

  // Memory port mux. These outputs are decoded from state, so an async reset
  // drops mem_wr_en immediately.
  always_comb begin
    mem_addr  = scrub_ptr;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_we;
    end else if (state == S_WB) begin
      mem_wdata = scrub_data;
      mem_wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      scrub_ptr  <= '0;
      scrub_data <= '0;
      corr_count <= '0;
      pass_done  <= 1'b0;
      scrub_busy <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      scrub_ptr  <= ptr_nx;
      scrub_data <= data_nx;
      if (count_inc && corr_count != 8'hFF) corr_count <= corr_count + 8'd1;
      pass_done  <= ptr_adv && (scrub_ptr == LAST_PTR);
      scrub_busy <= (state_nx == S_RD) || (state_nx == S_WB);
      host_ack   <= host_gnt;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Bench for ecc_scrub_controller with SCRUB_INTERVAL=4 and DEPTH=16.
// The memory stand-in returns the stored (corrected) byte. It raises
// mem_corrected while an address has an injected fault that no write has
// repaired yet. Faults are injected by bumping flt_gen[a]. Any write to
// address a repairs it, because the memory copies flt_gen[a] into flt_fix[a].
module tb_ecc_scrub_controller;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH = 16;
  localparam int SCRUB_INTERVAL = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  logic              clk, rst, scrub_en, host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_corrected;
  logic              scrub_busy, pass_done;
  logic [7:0]        corr_count;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_data [DEPTH];
  int flt_gen [DEPTH];
  int flt_fix [DEPTH];

  ecc_scrub_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_corrected(mem_corrected),
    .scrub_busy(scrub_busy), .pass_done(pass_done), .corr_count(corr_count),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory stand-in
  assign mem_rdata     = mem_data[mem_addr];
  assign mem_corrected = (flt_gen[mem_addr] != flt_fix[mem_addr]);
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem_data[mem_addr] <= mem_wdata;
      flt_fix[mem_addr]  <= flt_gen[mem_addr];
    end
  end

  function automatic logic [7:0] pre_data(input int i);
    logic [3:0] n;
    n = i[3:0];
    return (i == 5) ? 8'h5A : {n, ~n};
  endfunction

  // Waits for an RD cycle at address a. n is the number of edges waited.
  task automatic wait_rd(input logic [3:0] a, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (dbg_state == ST_RD && mem_addr == a && !host_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; scrub_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0h expected 0", host_ack); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", host_rdata); end
    checks++; if (corr_count !== 8'h00) begin errors++; $display("FAIL reset_corr: got %0h expected 0", corr_count); end
    checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL reset_pass_done: got %0h expected 0", pass_done); end
    checks++; if (scrub_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", scrub_busy); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0h expected 0", mem_wr_en); end
    checks++; if (mem_addr !== 4'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0h expected %0h", dbg_state, ST_IDLE); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_hold: got %0h expected %0h", dbg_state, ST_IDLE); end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd3; host_wdata = 8'hA5;
    #1;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %0h expected 1", host_gnt); end
    checks++; if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'd3, 8'hA5}) begin errors++; $display("FAIL wr_mem_port: got %0h expected %0h", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 4'd3, 8'hA5}); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early: got %0h expected 0", host_ack); end
    @(posedge clk); #1;
    host_req = 1'b0;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %0h expected 1", host_ack); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_hold: got %0h expected 0", host_rdata); end
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
    #1;
    checks++; if (host_gnt !== 1'b1 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL rd_gnt: got gnt %0h wr_en %0h expected 1 0", host_gnt, mem_wr_en); end
    @(posedge clk); #1;
    host_req = 1'b0;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %0h expected 1", host_ack); end
    checks++; if (host_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got %0h expected a5", host_rdata); end
    @(posedge clk); #1;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %0h expected 0", host_ack); end
  endtask

  // Preloads every word with consecutive granted writes.
  task automatic test_back_to_back;
    int gnts, acks, bad;
    gnts = 0; acks = 0; bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 4'(i); host_wdata = pre_data(i);
      #1;
      if (host_gnt === 1'b1) gnts++;
      @(posedge clk); #1;
      if (host_ack === 1'b1) acks++;
    end
    host_req = 1'b0;
    checks++; if (gnts != DEPTH) begin errors++; $display("FAIL b2b_gnts: got %0d expected %0d", gnts, DEPTH); end
    checks++; if (acks != DEPTH) begin errors++; $display("FAIL b2b_acks: got %0d expected %0d", acks, DEPTH); end
    for (int i = 0; i < DEPTH; i++) if (mem_data[i] !== pre_data(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_contents: got %0d bad words expected 0", bad); end
  endtask

  // One IDLE cycle, then 16 words at SCRUB_INTERVAL+1 = 5 cycles each.
  // pass_done is therefore first seen after edge 81.
  task automatic test_clean_pass;
    int cyc, busy_cnt, wr_seen;
    cyc = 0; busy_cnt = 0; wr_seen = 0;
    @(negedge clk) scrub_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (scrub_busy) busy_cnt++;
      if (mem_wr_en) wr_seen++;
      if (pass_done) break;
    end
    checks++; if (cyc != 81) begin errors++; $display("FAIL pass_time: got %0d expected 81", cyc); end
    checks++; if (busy_cnt != 16) begin errors++; $display("FAIL pass_busy_cycles: got %0d expected 16", busy_cnt); end
    checks++; if (wr_seen != 0) begin errors++; $display("FAIL pass_wr_en: got %0d expected 0", wr_seen); end
    checks++; if (corr_count !== 8'h00) begin errors++; $display("FAIL pass_corr: got %0h expected 0", corr_count); end
    @(posedge clk); #1;
    checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL pass_pulse: got %0h expected 0", pass_done); end
  endtask

  task automatic test_fault_repair;
    bit ok;
    int n;
    flt_gen[5]++;
    wait_rd(4'd5, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL fix_reach_rd5: got timeout expected RD at 5"); end
    checks++; if (mem_wr_en !== 1'b0 || scrub_busy !== 1'b1) begin errors++; $display("FAIL fix_rd: got wr_en %0h busy %0h expected 0 1", mem_wr_en, scrub_busy); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_WB) begin errors++; $display("FAIL fix_wb_state: got %0h expected %0h", dbg_state, ST_WB); end
    checks++; if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'd5, 8'h5A}) begin errors++; $display("FAIL fix_wb_port: got %0h expected %0h", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 4'd5, 8'h5A}); end
    @(posedge clk); #1;
    checks++; if (corr_count !== 8'd1) begin errors++; $display("FAIL fix_count: got %0d expected 1", corr_count); end
    checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL fix_after_wb: got %0h expected %0h", dbg_state, ST_WAIT); end
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd5;
    #1;
    checks++; if (mem_corrected !== 1'b0) begin errors++; $display("FAIL fix_reread_corrected: got %0h expected 0", mem_corrected); end
    @(posedge clk); #1;
    host_req = 1'b0;
    checks++; if (host_rdata !== 8'h5A) begin errors++; $display("FAIL fix_reread_data: got %0h expected 5a", host_rdata); end
  endtask

  task automatic test_collision;
    bit ok;
    int n;
    flt_gen[8]++;
    wait_rd(4'd7, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL col_reach_rd7: got timeout expected RD at 7"); end
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
    #1;
    checks++; if (host_gnt !== 1'b1 || mem_addr !== 4'd2) begin errors++; $display("FAIL col_rd_gnt: got gnt %0h addr %0h expected 1 2", host_gnt, mem_addr); end
    @(posedge clk); #1;
    host_req = 1'b0;
    #1;
    checks++; if (host_ack !== 1'b1 || host_rdata !== pre_data(2)) begin errors++; $display("FAIL col_host_data: got ack %0h data %0h expected 1 %0h", host_ack, host_rdata, pre_data(2)); end
    checks++; if (dbg_state !== ST_RD || mem_addr !== 4'd7) begin errors++; $display("FAIL col_rd_repeat: got state %0h addr %0h expected %0h 7", dbg_state, mem_addr, ST_RD); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL col_rd_done: got %0h expected %0h", dbg_state, ST_WAIT); end
    wait_rd(4'd8, ok, n);
    checks++; if (!ok || n != 4) begin errors++; $display("FAIL col_next_ptr: got ok %0d edges %0d expected 1 4", ok, n); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_WB) begin errors++; $display("FAIL col_wb_state: got %0h expected %0h", dbg_state, ST_WB); end
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd1; host_wdata = 8'h3C;
    #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL col_wb_no_gnt: got %0h expected 0", host_gnt); end
    checks++; if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'd8, pre_data(8)}) begin errors++; $display("FAIL col_wb_port: got %0h expected %0h", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 4'd8, pre_data(8)}); end
    @(posedge clk); #1;
    checks++; if (host_gnt !== 1'b1 || host_ack !== 1'b0) begin errors++; $display("FAIL col_late_gnt: got gnt %0h ack %0h expected 1 0", host_gnt, host_ack); end
    checks++; if (corr_count !== 8'd2) begin errors++; $display("FAIL col_count: got %0d expected 2", corr_count); end
    @(posedge clk); #1;
    host_req = 1'b0;
    checks++; if (host_ack !== 1'b1 || mem_data[1] !== 8'h3C) begin errors++; $display("FAIL col_late_write: got ack %0h mem %0h expected 1 3c", host_ack, mem_data[1]); end
  endtask

  task automatic test_disable_resume;
    bit ok;
    int n;
    wait_rd(4'd9, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL dis_reach_rd9: got timeout expected RD at 9"); end
    @(negedge clk) scrub_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_IDLE || mem_addr !== 4'd10 || scrub_busy !== 1'b0) begin errors++; $display("FAIL dis_clean_idle: got state %0h addr %0h busy %0h expected 0 a 0", dbg_state, mem_addr, scrub_busy); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL dis_stay_idle: got %0h expected %0h", dbg_state, ST_IDLE); end
    @(negedge clk) scrub_en = 1'b1;
    wait_rd(4'd10, ok, n);
    checks++; if (!ok || n != 5) begin errors++; $display("FAIL dis_resume10: got ok %0d edges %0d expected 1 5", ok, n); end
    flt_gen[12]++;
    wait_rd(4'd12, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL dis_reach_rd12: got timeout expected RD at 12"); end
    @(negedge clk) scrub_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_WB || mem_wr_en !== 1'b1 || mem_addr !== 4'd12) begin errors++; $display("FAIL dis_wb_completes: got state %0h wr_en %0h addr %0h expected 3 1 c", dbg_state, mem_wr_en, mem_addr); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_IDLE || mem_addr !== 4'd13) begin errors++; $display("FAIL dis_wb_idle: got state %0h addr %0h expected 0 d", dbg_state, mem_addr); end
    checks++; if (corr_count !== 8'd3) begin errors++; $display("FAIL dis_count: got %0d expected 3", corr_count); end
  endtask

  // corr_count enters at 3. It reaches 254 after 251 more write-backs and
  // 255 after 252, then holds there.
  task automatic test_saturation;
    int wb_done;
    bit prev_wb;
    wb_done = 0; prev_wb = 1'b0;
    @(negedge clk) scrub_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      for (int a = 0; a < DEPTH; a++) if (flt_gen[a] == flt_fix[a]) flt_gen[a]++;
      @(posedge clk); #1;
      if (prev_wb) begin
        wb_done++;
        if (wb_done == 251) begin
          checks++; if (corr_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", corr_count); end
        end
        if (wb_done == 252) begin
          checks++; if (corr_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", corr_count); end
        end
      end
      prev_wb = (dbg_state == ST_WB);
      if (wb_done == 300) break;
    end
    checks++; if (wb_done != 300) begin errors++; $display("FAIL sat_wb_total: got %0d expected 300", wb_done); end
    checks++; if (corr_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", corr_count); end
  endtask

  task automatic test_reset_mid_wb;
    bit found;
    logic [3:0] a;
    found = 1'b0;
    a = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (dbg_state == ST_WB) begin
        found = 1'b1;
        a = mem_addr;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstwb_reach: got timeout expected WB"); end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstwb_drop: got wr_en %0h state %0h expected 0 0", mem_wr_en, dbg_state); end
    checks++; if (corr_count !== 8'd0 || scrub_busy !== 1'b0) begin errors++; $display("FAIL rstwb_regs: got corr %0h busy %0h expected 0 0", corr_count, scrub_busy); end
    @(posedge clk); #1;
    checks++; if (flt_gen[a] == flt_fix[a]) begin errors++; $display("FAIL rstwb_lost: got repaired expected still faulty at %0h", a); end
    @(negedge clk) rst = 1'b1;
    scrub_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clean_pass();
    test_fault_repair();
    test_collision();
    test_disable_resume();
    test_saturation();
    test_reset_mid_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
